restoring_divider_core: RTL and testbench



---
 rtl/restoring_divider_core.sv | 181 ++++++++++++++++++
 tb/tb_restoring_divider_core.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/restoring_divider_core.sv
//------------------------------------------------------------------------------
// Module   : restoring_divider_core
// Purpose  : Sequential unsigned restoring divider, 12-bit dividend by 6-bit
//            divisor, one quotient bit per SUB/RESTORE pair. Start/done
//            handshake; a start held high is not re-accepted until it drops.
//            Optional macro RESDIV_OVF_EN adds the registered ovf output.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module restoring_divider_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] dividend,
  input  logic [5:0]  divisor,
  input  logic        start,
  output logic [5:0]  quotient,
  output logic [6:0]  rem,
  output logic        done
`ifdef RESDIV_OVF_EN
  ,
  output logic        ovf
`endif
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_SUB       = 3'd2;
  localparam logic [2:0] S_RESTORE   = 3'd3;
  localparam logic [2:0] S_FINISH    = 3'd4;
  localparam logic [2:0] S_DONE_WAIT = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [11:0] dvd_q, dvd_d;        // latched dividend
  logic [5:0]  dvs_q, dvs_d;        // latched divisor
  logic [7:0]  r_q, r_d;            // partial remainder; bit 7 is the sign of T
  logic [5:0]  q_q, q_d;            // quotient under construction
  logic [2:0]  idx_q, idx_d;        // current quotient bit index
  logic [5:0]  quotient_q, quotient_d;
  logic [6:0]  rem_q, rem_d;
  logic        done_q, done_d;
`ifdef RESDIV_OVF_EN
  logic        ovf_path_q, ovf_path_d;
  logic        ovf_q, ovf_d;
`endif

  logic [5:0]  w_dlow;
  logic        w_dbit;

  // Low dividend bits are shifted in one per iteration, MSB first.
  assign w_dlow = dvd_q[5:0];
  assign w_dbit = w_dlow[idx_q];

  // Next-state and datapath computation for the divider FSM.
  always_comb begin
    state_d    = state_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    r_d        = r_q;
    q_d        = q_q;
    idx_d      = idx_q;
    quotient_d = quotient_q;
    rem_d      = rem_q;
    done_d     = done_q;
`ifdef RESDIV_OVF_EN
    ovf_path_d = ovf_path_q;
    ovf_d      = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Operands are captured on the accepting edge so later input
          // changes cannot disturb the running division.
          dvd_d   = dividend;
          dvs_d   = divisor;
          done_d  = 1'b0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        idx_d = 3'd5;
        q_d   = 6'd0;
        r_d   = {2'b00, dvd_q[11:6]};
        // A high half not below the divisor (including divisor 0) would
        // need more than 6 quotient bits: saturate instead of iterating.
        if (dvd_q[11:6] >= dvs_q) begin
          q_d     = 6'h3F;
          r_d     = 8'h7F;
`ifdef RESDIV_OVF_EN
          ovf_path_d = 1'b1;
`endif
          state_d = S_FINISH;
        end else begin
`ifdef RESDIV_OVF_EN
          ovf_path_d = 1'b0;
`endif
          state_d = S_SUB;
        end
      end
      S_SUB: begin
        r_d     = {r_q[6:0], w_dbit} - {2'b00, dvs_q};
        state_d = S_RESTORE;
      end
      S_RESTORE: begin
        if (r_q[7]) begin
          // Trial subtraction went negative: add the divisor back.
          r_d        = r_q + {2'b00, dvs_q};
          q_d[idx_q] = 1'b0;
        end else begin
          q_d[idx_q] = 1'b1;
        end
        if (idx_q == 3'd0) begin
          state_d = S_FINISH;
        end else begin
          idx_d   = idx_q - 3'd1;
          state_d = S_SUB;
        end
      end
      S_FINISH: begin
        quotient_d = q_q;
        rem_d      = r_q[6:0];
        done_d     = 1'b1;
`ifdef RESDIV_OVF_EN
        ovf_d      = ovf_path_q;
`endif
        state_d    = S_DONE_WAIT;
      end
      S_DONE_WAIT: begin
        if (!start) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      dvd_q      <= 12'd0;
      dvs_q      <= 6'd0;
      r_q        <= 8'd0;
      q_q        <= 6'd0;
      idx_q      <= 3'd0;
      quotient_q <= 6'd0;
      rem_q      <= 7'd0;
      done_q     <= 1'b0;
`ifdef RESDIV_OVF_EN
      ovf_path_q <= 1'b0;
      ovf_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      r_q        <= r_d;
      q_q        <= q_d;
      idx_q      <= idx_d;
      quotient_q <= quotient_d;
      rem_q      <= rem_d;
      done_q     <= done_d;
`ifdef RESDIV_OVF_EN
      ovf_path_q <= ovf_path_d;
      ovf_q      <= ovf_d;
`endif
    end
  end

  assign quotient = quotient_q;
  assign rem      = rem_q;
  assign done     = done_q;
`ifdef RESDIV_OVF_EN
  assign ovf      = ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_restoring_divider_core.sv
//------------------------------------------------------------------------------
// Module   : tb_restoring_divider_core
// Purpose  : Self-checking bench for restoring_divider_core against an
//            arithmetic reference model (integer / and %, saturation rule).
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_restoring_divider_core;

  logic        clk;
  logic        rst_n;
  logic [11:0] dividend;
  logic [5:0]  divisor;
  logic        start;
  wire  [5:0]  quotient;
  wire  [6:0]  rem;
  wire         done;
`ifdef RESDIV_OVF_EN
  wire         ovf;
`endif

  int n_cmp;
  int n_err;
  logic [5:0] prev_q;
  logic [6:0] prev_r;

  restoring_divider_core dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .dividend (dividend),
    .divisor  (divisor),
    .start    (start),
    .quotient (quotient),
    .rem      (rem),
    .done     (done)
`ifdef RESDIV_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division, saturated when the quotient
  // would not fit in 6 bits or the divisor is zero.
  task automatic ref_div(input int a, input int b, output int q, output int r,
                         output int ov, output int lat);
    if (b == 0 || (a / 64) >= b) begin
      q = 63; r = 127; ov = 1; lat = 2;
    end else begin
      q = a / b; r = a % b; ov = 0; lat = 14;
    end
  endtask

  // Run one division. hold = number of accepting-edge-relative edges start
  // stays high (large value keeps it high past done). toggle scrambles the
  // operand inputs while the division runs.
  task automatic do_div(input int a, input int b, input int hold, input bit toggle);
    int eq, er, eov, elat, n;
    ref_div(a, b, eq, er, eov, elat);
    @(negedge clk);
    dividend = a[11:0];
    divisor  = b[5:0];
    start    = 1'b1;
    @(posedge clk); #1;
    check_eq("done_clear_on_accept", {31'd0, done}, 32'd0);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      if (n + 1 >= hold) start = 1'b0;
      if (toggle) begin
        dividend = $urandom;
        divisor  = $urandom;
      end
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        check_eq("quot_held_busy", {26'd0, quotient}, {26'd0, prev_q});
        check_eq("rem_held_busy", {25'd0, rem}, {25'd0, prev_r});
      end
    end
    check_eq("latency", n, elat);
    check_eq("quotient", {26'd0, quotient}, eq);
    check_eq("rem", {25'd0, rem}, er);
`ifdef RESDIV_OVF_EN
    check_eq("ovf", {31'd0, ovf}, eov);
`endif
    prev_q = quotient;
    prev_r = rem;
    if (start) begin
      // Start still high: result must be held with no retrigger.
      repeat (20) @(posedge clk);
      #1;
      check_eq("no_retrigger_done", {31'd0, done}, 32'd1);
      check_eq("no_retrigger_q", {26'd0, quotient}, eq);
      @(negedge clk);
      start = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    check_eq("done_held_idle", {31'd0, done}, 32'd1);
    check_eq("rem_held_idle", {25'd0, rem}, er);
  endtask

  initial begin
    int a, b;
    n_cmp    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    prev_q   = '0;
    prev_r   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_quotient", {26'd0, quotient}, 32'd0);
    check_eq("reset_rem", {25'd0, rem}, 32'd0);
    check_eq("reset_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_div(693, 11, 3, 1'b0);
    do_div(1685, 31, 1000, 1'b0);
    do_div(151, 26, 2, 1'b0);
    do_div(24, 1, 1, 1'b0);
    do_div(512, 16, 1, 1'b1);
    do_div(1000, 5, 1, 1'b0);
    do_div(100, 0, 1, 1'b0);
    do_div(4095, 63, 1, 1'b0);
    do_div(0, 1, 1, 1'b0);

    // Reset in the middle of the iterations.
    @(negedge clk);
    dividend = 12'd900;
    divisor  = 6'd50;
    start    = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_quotient", {26'd0, quotient}, 32'd0);
    check_eq("midrst_rem", {25'd0, rem}, 32'd0);
    check_eq("midrst_done", {31'd0, done}, 32'd0);
    start = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    prev_q = '0;
    prev_r = '0;
    do_div(900, 50, 1, 1'b0);

    // Random operands: mostly in range, some unconstrained.
    for (int k = 0; k < 24; k++) begin
      b = $urandom_range(63, 0);
      if (k % 4 == 3) a = $urandom_range(4095, 0);
      else if (b == 0) a = $urandom_range(4095, 0);
      else a = $urandom_range(b * 64 - 1, 0);
      do_div(a, b, $urandom_range(3, 1), k[0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
